regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: requester 0 is pipeline write-back, requester 1 is the multi-cycle unit (mul/div/hilo transfer).
- After reset, an init sequencer first clears every register through the same port.
- The block drives the regfile's we/waddr/wdata from registered outputs and sits between the WB stage, the multi-cycle unit and regfile.

---
 rtl/regfile_wr_arbiter_if.sv | 44 ++++
 rtl/regfile_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write arbiter bus.
// Groups the two requester handshakes and the regfile write port.
//   slave  : arbiter side (takes requests, drives ready and the write port)
//   master : environment side (WB stage / multi-cycle unit / regfile observer)
// Signals:
//   req0_valid/addr/data, req0_ready : pipeline write-back requester
//   req1_valid/addr/data, req1_ready : multi-cycle unit requester
//   we, waddr, wdata                 : registered regfile write port
//   init_done                        : clear sequence finished (RUN)
//   conflict                         : both requesters valid last RUN cycle
interface regfile_wr_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              init_done;
  logic              conflict;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output we, waddr, wdata, init_done, conflict
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  we, waddr, wdata, init_done, conflict
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Shares the single regfile write port between pipeline write-back (req0)
// and the multi-cycle unit (req1). After reset an optional init sequencer
// clears registers 0..NUM_REGS-1 through the same port before arbitration
// starts. The write port is driven from registers (one cycle after accept).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : regfile_wr_arbiter_if.slave (requests, readies, write port, status)
module regfile_wr_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned INIT_CLEAR = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REGS - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? S_INIT : S_RUN;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_last, w_last_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_init_done, w_init_done_nxt;
  logic              r_conflict, w_conflict_nxt;

  logic w_run;
  logic w_gnt0;
  logic w_gnt1;

  assign w_run = (r_state == S_RUN);

  // req0 wins a tie under fixed priority, or when req1 was granted last.
  assign w_gnt0 = w_run && bus.req0_valid &&
                  (!bus.req1_valid || (FIXED_PRIO != 0) || r_last);
  assign w_gnt1 = w_run && bus.req1_valid && !w_gnt0;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.init_done  = r_init_done;
  assign bus.conflict   = r_conflict;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_we_nxt        = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_conflict_nxt  = 1'b0;
    // init_done follows the state with one cycle of lag, so it rises the
    // cycle after the final clear write is visible on the port.
    w_init_done_nxt = w_run;

    case (r_state)
      S_INIT: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = ADDR_W'(r_cnt);
        w_wdata_nxt = '0;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_conflict_nxt = bus.req0_valid && bus.req1_valid;
        // Address 0 is accepted and moves the pointer, but never written.
        if (w_gnt0) begin
          w_last_nxt = 1'b0;
          if (bus.req0_addr != '0) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = bus.req0_addr;
            w_wdata_nxt = bus.req0_data;
          end
        end else if (w_gnt1) begin
          w_last_nxt = 1'b1;
          if (bus.req1_addr != '0) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = bus.req1_addr;
            w_wdata_nxt = bus.req1_data;
          end
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_init_done <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_we        <= w_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_init_done <= w_init_done_nxt;
      r_conflict  <= w_conflict_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst;

  regfile_wr_arbiter_if #(.ADDR_W(5), .DATA_W(32)) if_rr ();
  regfile_wr_arbiter_if #(.ADDR_W(5), .DATA_W(32)) if_fp ();

  regfile_wr_arbiter #(
    .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .INIT_CLEAR(1), .FIXED_PRIO(0)
  ) u_rr (
    .clk(clk),
    .rst(rst),
    .bus(if_rr.slave)
  );

  regfile_wr_arbiter #(
    .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .INIT_CLEAR(1), .FIXED_PRIO(1)
  ) u_fp (
    .clk(clk),
    .rst(rst),
    .bus(if_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  rdy_rr;  // {req1_ready, req0_ready}
    logic [1:0]  rdy_fp;
    logic        we_rr;
    logic [4:0]  wa_rr;
    logic [31:0] wd_rr;
    logic        we_fp;
    logic [4:0]  wa_fp;
    logic [31:0] wd_fp;
    logic        cf;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    if_rr.req0_valid = v0; if_rr.req0_addr = a0; if_rr.req0_data = d0;
    if_rr.req1_valid = v1; if_rr.req1_addr = a1; if_rr.req1_data = d1;
    if_fp.req0_valid = v0; if_fp.req0_addr = a0; if_fp.req0_data = d0;
    if_fp.req1_valid = v1; if_fp.req1_addr = a1; if_fp.req1_data = d1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rr.we"},        32'(if_rr.we), 32'd0);
    chk({tag, ".rr.waddr"},     32'(if_rr.waddr), 32'd0);
    chk({tag, ".rr.wdata"},     if_rr.wdata, 32'd0);
    chk({tag, ".rr.init_done"}, 32'(if_rr.init_done), 32'd0);
    chk({tag, ".rr.conflict"},  32'(if_rr.conflict), 32'd0);
    chk({tag, ".fp.we"},        32'(if_fp.we), 32'd0);
    chk({tag, ".fp.waddr"},     32'(if_fp.waddr), 32'd0);
    chk({tag, ".fp.wdata"},     if_fp.wdata, 32'd0);
    chk({tag, ".fp.init_done"}, 32'(if_fp.init_done), 32'd0);
    chk({tag, ".fp.conflict"},  32'(if_fp.conflict), 32'd0);
  endtask

  // Observes the clear sequence one negedge at a time; stop >= 0 returns
  // right after checking that index so the caller can pulse reset there.
  task automatic init_seq(input string tag, input int stop);
    drive(1'b1, 5'd1, 32'h55, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("%s.rr.we[%0d]", tag, i),        32'(if_rr.we), 32'd1);
      chk($sformatf("%s.rr.waddr[%0d]", tag, i),     32'(if_rr.waddr), 32'(i));
      chk($sformatf("%s.rr.wdata[%0d]", tag, i),     if_rr.wdata, 32'd0);
      chk($sformatf("%s.rr.init_done[%0d]", tag, i), 32'(if_rr.init_done), 32'd0);
      chk($sformatf("%s.fp.we[%0d]", tag, i),        32'(if_fp.we), 32'd1);
      chk($sformatf("%s.fp.waddr[%0d]", tag, i),     32'(if_fp.waddr), 32'(i));
      chk($sformatf("%s.fp.conflict[%0d]", tag, i),  32'(if_fp.conflict), 32'd0);
      if (i < 31) begin
        chk($sformatf("%s.rr.req0_ready[%0d]", tag, i), 32'(if_rr.req0_ready), 32'd0);
        chk($sformatf("%s.fp.req0_ready[%0d]", tag, i), 32'(if_fp.req0_ready), 32'd0);
      end
      if (i == 30) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      if (i == stop) return;
    end
    @(negedge clk);
    chk({tag, ".rr.we_after"},   32'(if_rr.we), 32'd0);
    chk({tag, ".rr.init_done"},  32'(if_rr.init_done), 32'd1);
    chk({tag, ".fp.init_done"},  32'(if_fp.init_done), 32'd1);
  endtask

  initial begin
    // {v0,a0,d0, v1,a1,d1, rdy_rr, rdy_fp, rr we/wa/wd, fp we/wa/wd, conflict}
    vt[0]  = '{1'b1, 5'd5, 32'h2345, 1'b0, 5'd0, 32'h0,    2'b01, 2'b01,
               1'b1, 5'd5, 32'h2345, 1'b1, 5'd5, 32'h2345, 1'b0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    2'b00, 2'b00,
               1'b0, 5'd5, 32'h2345, 1'b0, 5'd5, 32'h2345, 1'b0};
    vt[2]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h1234, 2'b10, 2'b10,
               1'b1, 5'd9, 32'h1234, 1'b1, 5'd9, 32'h1234, 1'b0};
    vt[3]  = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB, 2'b01, 2'b01,
               1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hAAAA, 1'b1};
    vt[4]  = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB, 2'b10, 2'b01,
               1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd3, 32'hAAAA, 1'b1};
    vt[5]  = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB, 2'b01, 2'b01,
               1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hAAAA, 1'b1};
    vt[6]  = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB, 2'b10, 2'b01,
               1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd3, 32'hAAAA, 1'b1};
    vt[7]  = '{1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0,    2'b01, 2'b01,
               1'b1, 5'd4, 32'h4444, 1'b1, 5'd4, 32'h4444, 1'b0};
    vt[8]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hFFFF, 2'b10, 2'b10,
               1'b0, 5'd4, 32'h4444, 1'b0, 5'd4, 32'h4444, 1'b0};
    vt[9]  = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB, 2'b01, 2'b01,
               1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hAAAA, 1'b1};
    vt[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    2'b00, 2'b00,
               1'b0, 5'd3, 32'hAAAA, 1'b0, 5'd3, 32'hAAAA, 1'b0};

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #12;
    chk_zero("por");
    @(negedge clk);
    rst = 1'b1;
    init_seq("init", -1);

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1);
      #1;
      chk($sformatf("rr.req0_ready[v%0d]", i), 32'(if_rr.req0_ready), 32'(vt[i].rdy_rr[0]));
      chk($sformatf("rr.req1_ready[v%0d]", i), 32'(if_rr.req1_ready), 32'(vt[i].rdy_rr[1]));
      chk($sformatf("fp.req0_ready[v%0d]", i), 32'(if_fp.req0_ready), 32'(vt[i].rdy_fp[0]));
      chk($sformatf("fp.req1_ready[v%0d]", i), 32'(if_fp.req1_ready), 32'(vt[i].rdy_fp[1]));
      @(negedge clk);
      chk($sformatf("rr.we[v%0d]", i),       32'(if_rr.we), 32'(vt[i].we_rr));
      chk($sformatf("rr.waddr[v%0d]", i),    32'(if_rr.waddr), 32'(vt[i].wa_rr));
      chk($sformatf("rr.wdata[v%0d]", i),    if_rr.wdata, vt[i].wd_rr);
      chk($sformatf("rr.conflict[v%0d]", i), 32'(if_rr.conflict), 32'(vt[i].cf));
      chk($sformatf("fp.we[v%0d]", i),       32'(if_fp.we), 32'(vt[i].we_fp));
      chk($sformatf("fp.waddr[v%0d]", i),    32'(if_fp.waddr), 32'(vt[i].wa_fp));
      chk($sformatf("fp.wdata[v%0d]", i),    if_fp.wdata, vt[i].wd_fp);
      chk($sformatf("fp.conflict[v%0d]", i), 32'(if_fp.conflict), 32'(vt[i].cf));
      chk($sformatf("rr.init_done[v%0d]", i), 32'(if_rr.init_done), 32'd1);
    end

    // Reset issued part-way through the clear sequence.
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk_zero("rst_run");
    @(negedge clk);
    rst = 1'b1;
    init_seq("pre_abort", 10);
    rst = 1'b0;
    #1;
    chk_zero("rst_mid_init");
    @(negedge clk);
    chk_zero("rst_mid_init_held");
    rst = 1'b1;
    init_seq("restart", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
